// File: rtl/pipe_pkg.sv
// Shared encodings for the ID/EX stage: ALU codes, opcode/funct values,
// operand-select enums and the registered control bundle.
package pipe_pkg;

   localparam int OP_W     = 6;
   localparam int FN_W     = 6;
   localparam int ALUCTL_W = 4;

   localparam logic [ALUCTL_W-1:0] ALU_AND = 4'd0;
   localparam logic [ALUCTL_W-1:0] ALU_OR  = 4'd1;
   localparam logic [ALUCTL_W-1:0] ALU_ADD = 4'd2;
   localparam logic [ALUCTL_W-1:0] ALU_SLL = 4'd3;
   localparam logic [ALUCTL_W-1:0] ALU_SRL = 4'd4;
   localparam logic [ALUCTL_W-1:0] ALU_SRA = 4'd5;
   localparam logic [ALUCTL_W-1:0] ALU_SUB = 4'd6;
   localparam logic [ALUCTL_W-1:0] ALU_SLT = 4'd7;
   localparam logic [ALUCTL_W-1:0] ALU_EQ  = 4'd8;
   localparam logic [ALUCTL_W-1:0] ALU_XOR = 4'd12;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [FN_W-1:0] FN_SLL  = 6'h00;
   localparam logic [FN_W-1:0] FN_SRL  = 6'h02;
   localparam logic [FN_W-1:0] FN_SRA  = 6'h03;
   localparam logic [FN_W-1:0] FN_ADD  = 6'h20;
   localparam logic [FN_W-1:0] FN_ADDU = 6'h21;
   localparam logic [FN_W-1:0] FN_SUB  = 6'h22;
   localparam logic [FN_W-1:0] FN_SUBU = 6'h23;
   localparam logic [FN_W-1:0] FN_AND  = 6'h24;
   localparam logic [FN_W-1:0] FN_OR   = 6'h25;
   localparam logic [FN_W-1:0] FN_XOR  = 6'h26;
   localparam logic [FN_W-1:0] FN_SLT  = 6'h2A;

   typedef enum logic [1:0] {ASEL_RS, ASEL_RT, ASEL_IMM} asel_e;
   typedef enum logic [1:0] {BSEL_RT, BSEL_SHAMT, BSEL_IMM, BSEL_C16} bsel_e;
   typedef enum logic {EXT_ZERO, EXT_SIGN} ext_e;

   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic branch;
   } ctl_t;

endpackage

// File: rtl/alu_ctl_dec.sv
// Combinational opcode/funct decoder: ALU code, operand selects, immediate
// extension mode, control bundle and an illegal-encoding flag.
module alu_ctl_dec
   import pipe_pkg::*;
(
   input  logic [OP_W-1:0]     opcode,
   input  logic [FN_W-1:0]     funct,
   output logic [ALUCTL_W-1:0] aluctl,
   output asel_e               a_sel,
   output bsel_e               b_sel,
   output ext_e                ext_mode,
   output logic                dest_rd,
   output ctl_t                ctl,
   output logic                illegal
);

   always_comb begin
      aluctl   = ALU_ADD;
      a_sel    = ASEL_RS;
      b_sel    = BSEL_RT;
      ext_mode = EXT_SIGN;
      dest_rd  = 1'b0;
      ctl      = '0;
      illegal  = 1'b0;
      if (opcode == OP_RTYPE) begin
         dest_rd      = 1'b1;
         ctl.regwrite = 1'b1;
         case (funct)
            FN_ADD, FN_ADDU: aluctl = ALU_ADD;
            FN_SUB, FN_SUBU: aluctl = ALU_SUB;
            FN_AND:          aluctl = ALU_AND;
            FN_OR:           aluctl = ALU_OR;
            FN_XOR:          aluctl = ALU_XOR;
            FN_SLT:          aluctl = ALU_SLT;
            // Shifts take the value from rt and the amount from shamt.
            FN_SLL: begin aluctl = ALU_SLL; a_sel = ASEL_RT; b_sel = BSEL_SHAMT; end
            FN_SRL: begin aluctl = ALU_SRL; a_sel = ASEL_RT; b_sel = BSEL_SHAMT; end
            FN_SRA: begin aluctl = ALU_SRA; a_sel = ASEL_RT; b_sel = BSEL_SHAMT; end
            default: begin illegal = 1'b1; ctl = '0; end
         endcase
      end else begin
         b_sel = BSEL_IMM;
         case (opcode)
            OP_ADDI, OP_ADDIU: begin aluctl = ALU_ADD; ctl.regwrite = 1'b1; end
            OP_SLTI: begin aluctl = ALU_SLT; ctl.regwrite = 1'b1; end
            OP_ANDI: begin aluctl = ALU_AND; ext_mode = EXT_ZERO; ctl.regwrite = 1'b1; end
            OP_ORI:  begin aluctl = ALU_OR;  ext_mode = EXT_ZERO; ctl.regwrite = 1'b1; end
            OP_XORI: begin aluctl = ALU_XOR; ext_mode = EXT_ZERO; ctl.regwrite = 1'b1; end
            // lui is executed as imm16 << 16 on the shifter.
            OP_LUI: begin
               aluctl       = ALU_SLL;
               a_sel        = ASEL_IMM;
               b_sel        = BSEL_C16;
               ext_mode     = EXT_ZERO;
               ctl.regwrite = 1'b1;
            end
            OP_LW: begin
               aluctl       = ALU_ADD;
               ctl.memread  = 1'b1;
               ctl.memtoreg = 1'b1;
               ctl.regwrite = 1'b1;
            end
            OP_SW:  begin aluctl = ALU_ADD; ctl.memwrite = 1'b1; end
            OP_BEQ: begin aluctl = ALU_EQ; b_sel = BSEL_RT; ctl.branch = 1'b1; end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decode, operand forwarding and selection, with
// stall (hold), flush (bubble) and a one-cycle illegal-encoding pulse.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [OP_W-1:0]     id_opcode,
   input  logic [FN_W-1:0]     id_funct,
   input  logic [4:0]          id_shamt,
   input  logic [15:0]         id_imm16,
   input  logic [REG_AW-1:0]   id_rs,
   input  logic [REG_AW-1:0]   id_rt,
   input  logic [REG_AW-1:0]   id_rd,
   input  logic [XLEN-1:0]     id_rs_val,
   input  logic [XLEN-1:0]     id_rt_val,
   input  logic                exmem_regwrite,
   input  logic [REG_AW-1:0]   exmem_rd,
   input  logic [XLEN-1:0]     exmem_result,
   input  logic                memwb_regwrite,
   input  logic [REG_AW-1:0]   memwb_rd,
   input  logic [XLEN-1:0]     memwb_result,
   input  logic                stall,
   input  logic                flush,
   output logic                ex_valid,
   output logic [ALUCTL_W-1:0] ex_aluctl,
   output logic [XLEN-1:0]     ex_a,
   output logic [XLEN-1:0]     ex_b,
   output logic [XLEN-1:0]     ex_store_data,
   output logic [REG_AW-1:0]   ex_dest,
   output logic                ex_regwrite,
   output logic                ex_memread,
   output logic                ex_memwrite,
   output logic                ex_memtoreg,
   output logic                ex_branch,
   output logic                ex_illegal
);

   logic [ALUCTL_W-1:0] dec_aluctl;
   asel_e               dec_a_sel;
   bsel_e               dec_b_sel;
   ext_e                dec_ext;
   logic                dec_dest_rd;
   ctl_t                dec_ctl;
   logic                dec_illegal;

   alu_ctl_dec u_dec (
      .opcode   (id_opcode),
      .funct    (id_funct),
      .aluctl   (dec_aluctl),
      .a_sel    (dec_a_sel),
      .b_sel    (dec_b_sel),
      .ext_mode (dec_ext),
      .dest_rd  (dec_dest_rd),
      .ctl      (dec_ctl),
      .illegal  (dec_illegal)
   );

   // Youngest producer wins; register 0 is hardwired and never forwarded.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [REG_AW-1:0] src,    input logic [XLEN-1:0] rf_val,
      input logic              em_we,  input logic [REG_AW-1:0] em_rd, input logic [XLEN-1:0] em_val,
      input logic              mw_we,  input logic [REG_AW-1:0] mw_rd, input logic [XLEN-1:0] mw_val);
      if (src == '0)                 return rf_val;
      if (em_we && (em_rd == src))   return em_val;
      if (mw_we && (mw_rd == src))   return mw_val;
      return rf_val;
   endfunction

   logic [XLEN-1:0]   rs_fwd, rt_fwd, imm_ext, a_mux, b_mux;
   logic [REG_AW-1:0] dest_mux;

   always_comb begin
      rs_fwd  = fwd_sel(id_rs, id_rs_val, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);
      rt_fwd  = fwd_sel(id_rt, id_rt_val, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);
      imm_ext = (dec_ext == EXT_SIGN) ? {{(XLEN-16){id_imm16[15]}}, id_imm16}
                                      : {{(XLEN-16){1'b0}}, id_imm16};
      case (dec_a_sel)
         ASEL_RS: a_mux = rs_fwd;
         ASEL_RT: a_mux = rt_fwd;
         default: a_mux = imm_ext;
      endcase
      case (dec_b_sel)
         BSEL_RT:    b_mux = rt_fwd;
         BSEL_SHAMT: b_mux = {{(XLEN-5){1'b0}}, id_shamt};
         BSEL_IMM:   b_mux = imm_ext;
         default:    b_mux = XLEN'(16);
      endcase
      dest_mux = dec_dest_rd ? id_rd : id_rt;
   end

   logic                valid_q,   valid_d;
   logic [ALUCTL_W-1:0] aluctl_q,  aluctl_d;
   logic [XLEN-1:0]     a_q,       a_d;
   logic [XLEN-1:0]     b_q,       b_d;
   logic [XLEN-1:0]     store_q,   store_d;
   logic [REG_AW-1:0]   dest_q,    dest_d;
   ctl_t                ctl_q,     ctl_d;
   logic                illegal_q, illegal_d;

   always_comb begin
      valid_d   = valid_q;
      aluctl_d  = aluctl_q;
      a_d       = a_q;
      b_d       = b_q;
      store_d   = store_q;
      dest_d    = dest_q;
      ctl_d     = ctl_q;
      illegal_d = illegal_q;
      // Bubbles clear valid and control only; the datapath keeps its last value.
      if (flush || (!stall && (!id_valid || dec_illegal))) begin
         valid_d   = 1'b0;
         ctl_d     = '0;
         illegal_d = !flush && id_valid && dec_illegal;
      end else if (!stall) begin
         valid_d      = 1'b1;
         aluctl_d     = dec_aluctl;
         a_d          = a_mux;
         b_d          = b_mux;
         store_d      = rt_fwd;
         dest_d       = dest_mux;
         ctl_d        = dec_ctl;
         ctl_d.regwrite = dec_ctl.regwrite && (dest_mux != '0);
         illegal_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         aluctl_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         store_q   <= '0;
         dest_q    <= '0;
         ctl_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         aluctl_q  <= aluctl_d;
         a_q       <= a_d;
         b_q       <= b_d;
         store_q   <= store_d;
         dest_q    <= dest_d;
         ctl_q     <= ctl_d;
         illegal_q <= illegal_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_aluctl     = aluctl_q;
   assign ex_a          = a_q;
   assign ex_b          = b_q;
   assign ex_store_data = store_q;
   assign ex_dest       = dest_q;
   assign ex_regwrite   = ctl_q.regwrite;
   assign ex_memread    = ctl_q.memread;
   assign ex_memwrite   = ctl_q.memwrite;
   assign ex_memtoreg   = ctl_q.memtoreg;
   assign ex_branch     = ctl_q.branch;
   assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_shamt;
   logic [15:0] id_imm16;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_val, id_rt_val;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        stall, flush;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_illegal;
   logic [3:0]  ex_aluctl;
   logic [31:0] ex_a, ex_b, ex_store_data;
   logic [4:0]  ex_dest;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        valid;
      logic [3:0]  aluctl;
      logic [31:0] a, b, sd;
      logic [4:0]  dest;
      logic        rw, mr, mw, mt, br, ill;
   } exp_t;

   exp_t got;
   exp_t mdl = '0;

   assign got = {ex_valid, ex_aluctl, ex_a, ex_b, ex_store_data, ex_dest,
                 ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_illegal};

   id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
      .id_shamt(id_shamt), .id_imm16(id_imm16), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_aluctl(ex_aluctl),
      .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   // Value a source operand should carry after forwarding.
   function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf);
      if (idx == 5'd0) return rf;
      if (exmem_regwrite && exmem_rd == idx) return exmem_result;
      if (memwb_regwrite && memwb_rd == idx) return memwb_result;
      return rf;
   endfunction

   // Next architectural EX-slot contents given the current inputs.
   function automatic exp_t model_next(input exp_t cur);
      exp_t n;
      logic ok;
      logic [31:0] ra, rb, se, ze;
      if (rst) return '0;
      n = cur;
      if (flush) begin
         n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.mt = 0; n.br = 0; n.ill = 0;
         return n;
      end
      if (stall) return cur;
      ra = src_val(id_rs, id_rs_val);
      rb = src_val(id_rt, id_rt_val);
      se = 32'($signed(id_imm16));
      ze = 32'(id_imm16);
      ok = 1;
      n.a = ra; n.b = rb; n.sd = rb; n.dest = id_rt;
      n.rw = 0; n.mr = 0; n.mw = 0; n.mt = 0; n.br = 0;
      if (id_opcode == 6'h00) begin
         n.dest = id_rd; n.rw = 1;
         case (id_funct)
            6'h20, 6'h21: n.aluctl = 2;
            6'h22, 6'h23: n.aluctl = 6;
            6'h24: n.aluctl = 0;
            6'h25: n.aluctl = 1;
            6'h26: n.aluctl = 12;
            6'h2A: n.aluctl = 7;
            6'h00: begin n.aluctl = 3; n.a = rb; n.b = 32'(id_shamt); end
            6'h02: begin n.aluctl = 4; n.a = rb; n.b = 32'(id_shamt); end
            6'h03: begin n.aluctl = 5; n.a = rb; n.b = 32'(id_shamt); end
            default: ok = 0;
         endcase
      end else begin
         case (id_opcode)
            6'h08, 6'h09: begin n.aluctl = 2;  n.b = se; n.rw = 1; end
            6'h0A:        begin n.aluctl = 7;  n.b = se; n.rw = 1; end
            6'h0C:        begin n.aluctl = 0;  n.b = ze; n.rw = 1; end
            6'h0D:        begin n.aluctl = 1;  n.b = ze; n.rw = 1; end
            6'h0E:        begin n.aluctl = 12; n.b = ze; n.rw = 1; end
            6'h0F:        begin n.aluctl = 3;  n.a = ze; n.b = 32'd16; n.rw = 1; end
            6'h23:        begin n.aluctl = 2;  n.b = se; n.mr = 1; n.mt = 1; n.rw = 1; end
            6'h2B:        begin n.aluctl = 2;  n.b = se; n.mw = 1; end
            6'h04:        begin n.aluctl = 8;  n.br = 1; end
            default: ok = 0;
         endcase
      end
      if (!id_valid || !ok) begin
         n = cur;
         n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.mt = 0; n.br = 0;
         n.ill = id_valid && !ok;
         return n;
      end
      if (n.dest == 5'd0) n.rw = 0;
      n.valid = 1;
      n.ill   = 0;
      return n;
   endfunction

   task automatic tick();
      mdl = model_next(mdl);
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                            input logic [15:0] imm);
      id_valid = 1; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
      id_shamt = sh; id_imm16 = imm;
   endtask

   task automatic no_fwd();
      exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   task automatic test_reset();
      rst = 1; stall = 0; flush = 0; no_fwd();
      set_instr(6'h00, 6'h20, 5'd3, 5'd4, 5'd7, 5'd0, 16'h0);
      id_rs_val = 32'd10; id_rt_val = 32'd5;
      tick(); tick();
      total++; if (got !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", got); end
      rst = 0;
   endtask

   task automatic test_add();
      set_instr(6'h00, 6'h20, 5'd3, 5'd4, 5'd7, 5'd0, 16'h0);
      id_rs_val = 32'd10; id_rt_val = 32'd5;
      tick();
      total++; if ({ex_valid, ex_aluctl, ex_regwrite, ex_dest} !== {1'b1, 4'd2, 1'b1, 5'd7}) begin
         bad++; $display("FAIL add_ctl got=%b/%0d/%b/%0d exp=1/2/1/7", ex_valid, ex_aluctl, ex_regwrite, ex_dest); end
      total++; if (ex_a !== 32'd10) begin bad++; $display("FAIL add_a got=%h exp=a", ex_a); end
      total++; if (ex_b !== 32'd5) begin bad++; $display("FAIL add_b got=%h exp=5", ex_b); end
   endtask

   task automatic test_forwarding();
      exmem_regwrite = 1; exmem_rd = 5'd3; exmem_result = 32'hAAAA;
      memwb_regwrite = 1; memwb_rd = 5'd3; memwb_result = 32'hBBBB;
      set_instr(6'h00, 6'h20, 5'd3, 5'd3, 5'd7, 5'd0, 16'h0);
      tick();
      total++; if (ex_a !== 32'hAAAA) begin bad++; $display("FAIL fwd_double_a got=%h exp=aaaa", ex_a); end
      total++; if (ex_b !== 32'hAAAA) begin bad++; $display("FAIL fwd_double_b got=%h exp=aaaa", ex_b); end
      exmem_regwrite = 0;
      tick();
      total++; if (ex_a !== 32'hBBBB) begin bad++; $display("FAIL fwd_memwb got=%h exp=bbbb", ex_a); end
      exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0; id_rs = 0; id_rt = 5'd4; id_rs_val = 32'h1234;
      tick();
      total++; if (ex_a !== 32'h1234) begin bad++; $display("FAIL fwd_r0 got=%h exp=1234", ex_a); end
      no_fwd();
   endtask

   task automatic test_immediates();
      set_instr(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF);
      tick();
      total++; if ({ex_aluctl, ex_b, ex_dest} !== {4'd2, 32'hFFFF_FFFF, 5'd2}) begin
         bad++; $display("FAIL addi got=%0d/%h/%0d exp=2/ffffffff/2", ex_aluctl, ex_b, ex_dest); end
      set_instr(6'h0D, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF);
      tick();
      total++; if ({ex_aluctl, ex_b} !== {4'd1, 32'h0000_FFFF}) begin
         bad++; $display("FAIL ori got=%0d/%h exp=1/0000ffff", ex_aluctl, ex_b); end
      set_instr(6'h0F, 6'h00, 5'd0, 5'd2, 5'd0, 5'd0, 16'h1234);
      tick();
      total++; if ({ex_aluctl, ex_a, ex_b} !== {4'd3, 32'h1234, 32'd16}) begin
         bad++; $display("FAIL lui got=%0d/%h/%h exp=3/1234/10", ex_aluctl, ex_a, ex_b); end
      exmem_regwrite = 1; exmem_rd = 5'd2; exmem_result = 32'hCAFE;
      set_instr(6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0004);
      tick();
      total++; if ({ex_store_data, ex_memwrite, ex_regwrite, ex_b} !== {32'hCAFE, 1'b1, 1'b0, 32'd4}) begin
         bad++; $display("FAIL sw got=%h/%b/%b/%h exp=cafe/1/0/4", ex_store_data, ex_memwrite, ex_regwrite, ex_b); end
      no_fwd();
      set_instr(6'h23, 6'h00, 5'd1, 5'd6, 5'd0, 5'd0, 16'h8000);
      tick();
      total++; if ({ex_memread, ex_memtoreg, ex_regwrite, ex_b} !== {3'b111, 32'hFFFF_8000}) begin
         bad++; $display("FAIL lw got=%b%b%b/%h exp=111/ffff8000", ex_memread, ex_memtoreg, ex_regwrite, ex_b); end
   endtask

   task automatic test_stall_flush();
      set_instr(6'h00, 6'h20, 5'd3, 5'd4, 5'd7, 5'd0, 16'h0);
      id_rs_val = 32'd10; id_rt_val = 32'd5;
      tick();
      stall = 1;
      set_instr(6'h00, 6'h22, 5'd8, 5'd9, 5'd9, 5'd0, 16'h0);
      id_rs_val = 32'd99; id_rt_val = 32'd98;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if ({ex_valid, ex_aluctl, ex_a, ex_b, ex_dest, ex_regwrite} !== {1'b1, 4'd2, 32'd10, 32'd5, 5'd7, 1'b1}) begin
            bad++; $display("FAIL stall_hold cyc=%0d got=%b/%0d/%h/%h/%0d exp=1/2/a/5/7", i, ex_valid, ex_aluctl, ex_a, ex_b, ex_dest); end
      end
      flush = 1;
      tick();
      total++; if ({ex_valid, ex_regwrite, ex_a} !== {1'b0, 1'b0, 32'd10}) begin
         bad++; $display("FAIL stall_flush got=%b/%b/%h exp=0/0/a", ex_valid, ex_regwrite, ex_a); end
      flush = 0; stall = 0;
      tick();
      total++; if ({ex_valid, ex_aluctl, ex_a} !== {1'b1, 4'd6, 32'd99}) begin
         bad++; $display("FAIL resume got=%b/%0d/%h exp=1/6/63", ex_valid, ex_aluctl, ex_a); end
      stall = 1; rst = 1;
      tick();
      total++; if (got !== '0) begin bad++; $display("FAIL rst_in_stall got=%h exp=0", got); end
      rst = 0; stall = 0;
   endtask

   task automatic test_illegal();
      set_instr(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
      tick();
      total++; if ({ex_valid, ex_illegal} !== 2'b01) begin
         bad++; $display("FAIL illegal_op got=%b%b exp=01", ex_valid, ex_illegal); end
      id_valid = 0;
      tick();
      total++; if (ex_illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse got=%b exp=0", ex_illegal); end
      set_instr(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
      tick();
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (ex_illegal !== 1'b1) begin bad++; $display("FAIL illegal_stall cyc=%0d got=%b exp=1", i, ex_illegal); end
      end
      stall = 0; id_valid = 0;
      tick();
      total++; if (ex_illegal !== 1'b0) begin bad++; $display("FAIL illegal_release got=%b exp=0", ex_illegal); end
      set_instr(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
      tick();
      total++; if ({ex_valid, ex_illegal, ex_regwrite} !== 3'b010) begin
         bad++; $display("FAIL illegal_funct got=%b%b%b exp=010", ex_valid, ex_illegal, ex_regwrite); end
      flush = 1;
      tick();
      total++; if (ex_illegal !== 1'b0) begin bad++; $display("FAIL illegal_flush got=%b exp=0", ex_illegal); end
      flush = 0;
   endtask

   task automatic test_shifts();
      set_instr(6'h00, 6'h00, 5'd0, 5'd5, 5'd6, 5'd4, 16'h0);
      id_rt_val = 32'd1;
      tick();
      total++; if ({ex_aluctl, ex_a, ex_b} !== {4'd3, 32'd1, 32'd4}) begin
         bad++; $display("FAIL sll got=%0d/%h/%h exp=3/1/4", ex_aluctl, ex_a, ex_b); end
      id_funct = 6'h03;
      tick();
      total++; if (ex_aluctl !== 4'd5) begin bad++; $display("FAIL sra got=%0d exp=5", ex_aluctl); end
      set_instr(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0010);
      id_rs_val = 32'd7; id_rt_val = 32'd7;
      tick();
      total++; if ({ex_aluctl, ex_branch, ex_regwrite, ex_b} !== {4'd8, 1'b1, 1'b0, 32'd7}) begin
         bad++; $display("FAIL beq got=%0d/%b/%b/%h exp=8/1/0/7", ex_aluctl, ex_branch, ex_regwrite, ex_b); end
      set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0);
      tick();
      total++; if ({ex_valid, ex_regwrite} !== 2'b10) begin
         bad++; $display("FAIL dest0 got=%b%b exp=10", ex_valid, ex_regwrite); end
   endtask

   localparam logic [5:0] OPS [11] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04};
   localparam logic [5:0] FNS [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02, 6'h03};

   task automatic test_random();
      rst = 1; tick(); rst = 0;
      for (int i = 0; i < 400; i++) begin
         rst            = ($urandom_range(0, 49) == 0);
         stall          = ($urandom_range(0, 5) == 0);
         flush          = ($urandom_range(0, 9) == 0);
         id_valid       = ($urandom_range(0, 7) != 0);
         id_opcode      = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 10)];
         id_funct       = ($urandom_range(0, 9) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 10)];
         id_shamt       = 5'($urandom);
         id_imm16       = 16'($urandom);
         id_rs          = 5'($urandom_range(0, 3));
         id_rt          = 5'($urandom_range(0, 3));
         id_rd          = 5'($urandom_range(0, 3));
         id_rs_val      = $urandom;
         id_rt_val      = $urandom;
         exmem_regwrite = 1'($urandom);
         exmem_rd       = 5'($urandom_range(0, 3));
         exmem_result   = $urandom;
         memwb_regwrite = 1'($urandom);
         memwb_rd       = 5'($urandom_range(0, 3));
         memwb_result   = $urandom;
         tick();
         total++; if (got !== mdl) begin
            bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, mdl); end
      end
      rst = 0; stall = 0; flush = 0;
   endtask

   initial begin
      rst = 1; stall = 0; flush = 0; id_valid = 0;
      id_opcode = 0; id_funct = 0; id_shamt = 0; id_imm16 = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_rs_val = 0; id_rt_val = 0;
      no_fwd();
      test_reset();
      test_add();
      test_forwarding();
      test_immediates();
      test_stall_flush();
      test_illegal();
      test_shifts();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
